// File: rtl/rv_pkg.sv
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared constants and fetch-state encoding for the RV front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register (valid/pc/instr) with load, flush, hold.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;

    // Flush only drops valid; pc/instr keep their last contents for debug visibility.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= XLEN'(NOP_INSTR);
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage: PC, imem addressing, IF/ID capture, halt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import rv_pkg::*;
#(
    parameter int              ADDR_W   = 7,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_instr,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_pc,
    output logic [XLEN-1:0]   if_instr,
    output logic              halted,
    output logic              fault
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_fault;
    logic            w_fault_set;
    logic            w_load;
    logic            w_flush;
    logic            w_pc_legal;

    assign w_pc_legal = (r_pc[1:0] == 2'b00) && (r_pc[XLEN-1:ADDR_W+2] == '0);
    assign imem_addr  = r_pc[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= r_fault | w_fault_set;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_fault_set = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!w_pc_legal) begin
                    w_state_nxt = ST_HALT;
                    w_flush     = 1'b1;
                    w_fault_set = 1'b1;
                end else if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                    w_flush  = 1'b1;
                end else if (!stall) begin
                    w_load = 1'b1;
                    // EBREAK leaves the PC pointing at itself for post-mortem inspection.
                    if (imem_instr == XLEN'(EBREAK_INSTR))
                        w_state_nxt = ST_HALT;
                    else
                        w_pc_nxt = r_pc + XLEN'(4);
                end
            end
            ST_HALT: w_flush = !stall;
            default: w_state_nxt = ST_HALT;
        endcase
    end

    if_id_reg #(
        .XLEN    (XLEN)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_instr (imem_instr),
        .o_valid (if_valid),
        .o_pc    (if_pc),
        .o_instr (if_instr)
    );

    assign halted = (r_state == ST_HALT);
    assign fault  = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit with a small imem.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int ADDR_W = 7;
    localparam int XLEN   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]   imem_instr;
    logic              stall = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [XLEN-1:0]   redirect_pc = '0;
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [XLEN-1:0]   if_instr;
    logic              halted;
    logic              fault;

    logic [XLEN-1:0]   mem [0:(1<<ADDR_W)-1];
    int                n_checks = 0;
    int                n_fail   = 0;

    assign imem_instr = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W         (ADDR_W),
        .XLEN           (XLEN),
        .RESET_PC       (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .halted         (halted),
        .fault          (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_program();
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        mem[3] = 32'h0030_8193;
        mem[4] = 32'h0010_0073;
    endtask

    // Reset, release, and pass through BOOT; afterwards the next tick captures pc 0.
    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_pc"},    if_pc, 32'd0);
        chk({tag, "_instr"}, if_instr, 32'h0000_0013);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_addr"},  {25'd0, imem_addr}, 32'd0);
    endtask

    initial begin
        load_program();

        // Reset values
        tick();
        chk_reset_state("rst");
        rst = 1'b0;
        tick();
        chk("boot_valid", {31'd0, if_valid}, 32'd0);

        // Sequential fetch
        tick();
        chk("f0_pc", if_pc, 32'd0);
        chk("f0_instr", if_instr, 32'h0000_0013);
        chk("f0_valid", {31'd0, if_valid}, 32'd1);
        tick();
        chk("f1_pc", if_pc, 32'd4);
        chk("f1_instr", if_instr, 32'h0010_0093);

        // Stall three cycles with if_pc=4
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", if_pc, 32'd4);
            chk("stall_instr", if_instr, 32'h0010_0093);
            chk("stall_addr", {25'd0, imem_addr}, 32'd2);
        end
        stall = 1'b0;
        tick();
        chk("rel_pc", if_pc, 32'd8);
        chk("rel_instr", if_instr, 32'h0020_0113);

        // Redirect wins over stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd0;
        tick();
        stall = 1'b0; redirect_valid = 1'b0;
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_addr", {25'd0, imem_addr}, 32'd0);
        tick();
        chk("redir_pc", if_pc, 32'd0);
        chk("redir_v1", {31'd0, if_valid}, 32'd1);
        tick(); chk("s4_pc", if_pc, 32'd4);
        tick(); chk("s8_pc", if_pc, 32'd8);
        tick();
        chk("s12_pc", if_pc, 32'd12);
        chk("s12_instr", if_instr, 32'h0030_8193);

        // EBREAK halts cleanly
        tick();
        chk("eb_instr", if_instr, 32'h0010_0073);
        chk("eb_pc", if_pc, 32'd16);
        chk("eb_valid", {31'd0, if_valid}, 32'd1);
        chk("eb_halted", {31'd0, halted}, 32'd1);
        chk("eb_fault", {31'd0, fault}, 32'd0);
        chk("eb_addr", {25'd0, imem_addr}, 32'd4);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        chk("halt_valid", {31'd0, if_valid}, 32'd0);
        chk("halt_addr", {25'd0, imem_addr}, 32'd4);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        tick();
        chk("halt_addr2", {25'd0, imem_addr}, 32'd4);

        // Misaligned redirect target
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect_valid = 1'b0;
        chk("mis_pre_fault", {31'd0, fault}, 32'd0);
        tick();
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_halted", {31'd0, halted}, 32'd1);
        chk("mis_valid", {31'd0, if_valid}, 32'd0);

        // Out-of-range redirect target
        do_reset();
        chk("rst2_fault", {31'd0, fault}, 32'd0);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("oor_pre_fault", {31'd0, fault}, 32'd0);
        tick();
        chk("oor_fault", {31'd0, fault}, 32'd1);
        chk("oor_halted", {31'd0, halted}, 32'd1);
        chk("oor_valid", {31'd0, if_valid}, 32'd0);

        // Fetch off the end of a NOP-only memory
        mem[4] = 32'h0000_0013;
        do_reset();
        for (int i = 0; i < 127; i++) tick();
        chk("end_pre_pc", if_pc, 32'h1F8);
        tick();
        chk("end_pc", if_pc, 32'h1FC);
        chk("end_valid", {31'd0, if_valid}, 32'd1);
        chk("end_fault0", {31'd0, fault}, 32'd0);
        tick();
        chk("wrap_fault", {31'd0, fault}, 32'd1);
        chk("wrap_halted", {31'd0, halted}, 32'd1);
        chk("wrap_valid", {31'd0, if_valid}, 32'd0);

        // Reset from the faulted state, then restart
        rst = 1'b1;
        tick();
        chk_reset_state("rst3");
        rst = 1'b0;
        tick();
        tick();
        chk("restart_pc", if_pc, 32'd0);
        chk("restart_valid", {31'd0, if_valid}, 32'd1);
        tick();
        chk("restart_pc4", if_pc, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
